// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and one borrow flop do the work; the
// result is presented as {borrow_out, difference}, matching the adder's format.
//
// state | meaning
// IDLE  | waiting for start; diff holds the last completed result
// SHIFT | one difference bit produced per edge, WIDTH edges in total
// DONE  | single-cycle result-valid pulse; a new start is accepted here
module serial_sub #(
  parameter int WIDTH = 4,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bor;
  logic             bor_nxt;
  logic             d;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs.
  assign d       = a_sr[0] ^ b_sr[0] ^ bor;
  assign bor_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
  assign last    = (cnt == CW'(WIDTH - 1));

  // Next-state decode; DONE accepts start directly for back-to-back operation.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy/done are flopped from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand shift registers, borrow flop, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      bor    <= bin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d, res_sr[WIDTH-1:1]};
      bor    <= bor_nxt;
      cnt    <= cnt + CW'(1);
      // diff only ever sees a complete word, never a partial result.
      if (last) diff <= {bor_nxt, d, res_sr[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed-vector and scoreboard bench for the 4-bit serial subtractor.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [4:0] diff;

  int checks   = 0;
  int failures = 0;

  serial_sub #(.WIDTH(4), .CW(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present operands and a one-cycle start; returns just after the sampling edge.
  task automatic launch(input logic [3:0] av, input logic [3:0] bv, input logic bv_in);
    @(negedge clk);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'hx; b = 4'hx; bin = 1'bx;
  endtask

  // Counts edges until done is seen (bounded) and cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, bcyc, pulses;
  logic [4:0] model;
  logic [3:0] ra, rb;
  logic       rbin;

  initial begin
    vecs[0] = '{4'b0110, 4'b1100, 1'b1, 5'b11001};
    vecs[1] = '{4'b1101, 4'b0011, 1'b0, 5'b01010};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 5'b11111};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0, 5'b00000};
    vecs[4] = '{4'b0000, 4'b0000, 1'b1, 5'b11111};
    vecs[5] = '{4'b1111, 4'b0000, 1'b0, 5'b01111};
    vecs[6] = '{4'b1000, 4'b0111, 1'b1, 5'b00000};
    vecs[7] = '{4'b0000, 4'b1111, 1'b0, 5'b10001};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #23;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_diff", diff, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_diff", diff, 5'b00000);

    // Directed vectors: latency, busy width, result, single-cycle done.
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done(lat, bcyc);
      check($sformatf("vec%0d_done", i), done, 1'b1);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, 4);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      check($sformatf("vec%0d_diff_hold", i), diff, vecs[i].exp);
    end

    // Busy lockout: second start two cycles in must be ignored.
    launch(4'b1101, 4'b0011, 1'b0);
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("lockout_pulses", pulses, 1);
    check("lockout_diff", diff, 5'b01010);
    check("lockout_idle", busy, 1'b0);

    // Back-to-back: start held through the DONE cycle.
    launch(4'b0110, 4'b1100, 1'b1);
    wait_done(lat, bcyc);
    check("b2b_first_diff", diff, 5'b11001);
    a = 4'b0011; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_no_idle", busy, 1'b1);
    check("b2b_done_low", done, 1'b0);
    check("b2b_diff_not_cleared", diff, 5'b11001);
    wait_done(lat, bcyc);
    check("b2b_latency", lat, 4);
    check("b2b_second_diff", diff, 5'b11110);

    // Reset mid-operation: immediate clear, no done pulse, then recovery.
    launch(4'b1101, 4'b0011, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_diff_after", diff, 5'b00000);
    launch(4'b1101, 4'b0011, 1'b0);
    wait_done(lat, bcyc);
    check("midrst_recover_latency", lat, 4);
    check("midrst_recover_diff", diff, 5'b01010);

    // Random scoreboard against an arithmetic reference.
    for (int i = 0; i < 500; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rbin = 1'($urandom_range(0, 1));
      model = {1'b0, ra} - {1'b0, rb} - {4'b0, rbin};
      launch(ra, rb, rbin);
      wait_done(lat, bcyc);
      check($sformatf("rand%0d_a%0h_b%0h_bin%0d", i, ra, rb, rbin), diff, model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor. Computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single full-subtractor cell and a borrow flop.
- Counterpart to the 4-bit carry-lookahead adder.
- Serves the datapath where area matters more than latency.
- Result is presented in the adder's format: a WIDTH+1-bit word whose MSB is the borrow-out.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- CW, 6, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; operands are sampled on a clk edge where start=1 and the block is not busy.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff is valid.
- diff  output  WIDTH+1  result; diff[WIDTH-1:0] = (a-b-bin) mod 2^WIDTH, diff[WIDTH] = borrow-out (1 when a < b+bin, unsigned).

Behaviour:
- Reset (rst_n=0, asynchronous, overrides everything):
  - state=IDLE; busy=0, done=0, diff=0.
  - Internal shift registers, borrow flop and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at edge k: latch a, b into shift registers, load borrow flop with bin, counter=0, go to SHIFT.
  - busy=1 from edge k.
- SHIFT (one bit per edge):
  - d = a_sr[0] ^ b_sr[0] ^ bor.
  - bor_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor).
  - d is shifted into the result register from the MSB side; a_sr and b_sr shift right; counter increments.
  - After the WIDTH-th bit (edge k+WIDTH): diff[WIDTH-1:0] = result, diff[WIDTH] = final borrow; go to DONE; busy=0, done=1.
- DONE:
  - Lasts exactly one cycle; done=1 (registered pulse, high between edges k+WIDTH and k+WIDTH+1).
  - Next state is IDLE, unless start=1 at that edge, in which case it behaves as IDLE accepting start and goes directly to SHIFT (back-to-back operation).
- Latency: start sampled at edge k → done high after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- diff holds its value until the next completed operation. It is not cleared on start and never shows partial results.
- start while busy=1 is ignored; operands are not re-sampled. a, b, bin may change freely after the sampling edge.
- Reset asserted mid-SHIFT: operation is abandoned, outputs return to reset values immediately, no done pulse.
- Wrap-around: the result is always modulo 2^WIDTH, with borrow reported in the MSB. No saturation and no signed overflow flag.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → busy=0, done=0, diff=5'b00000 before the next edge. Release and idle with start=0 → outputs stay at 0.
- a=4'b0110, b=4'b1100, bin=1, start pulse → done exactly 4 edges after sampling, diff=5'b11001 (borrow=1, low bits 9 = -7 mod 16). busy high for exactly 4 cycles.
- a=4'b1101, b=4'b0011, bin=0 → diff=5'b01010 (10, no borrow). Then a=4'b1111, b=4'b1111, bin=1 → diff=5'b11111. Then a=0, b=0, bin=0 → diff=5'b00000.
- Busy lockout: start re-asserted with a=4'b0001, b=4'b0001 two cycles into an operation on a=4'b1101, b=4'b0011 → ignored. diff=5'b01010 and a single done pulse.
- Back-to-back: start held high through the DONE cycle with new operands a=4'b0011, b=4'b0101, bin=0 → second operation begins with no IDLE cycle; diff=5'b11110 after a further 4 edges.
- Reset mid-operation: rst_n pulsed low after 2 SHIFT cycles → no done pulse, diff=0. A fresh start then gives the correct result.
- Scoreboard: random a, b, bin over 500 operations → diff equals {borrow, (a-b-bin) mod 16} computed by a reference model.
